// File: rtl/datapath_regs.sv
// Accumulator-CPU datapath: register bank, shared 16-bit bus and 2-phase ALU.
// Optional R5 register is enabled by defining DATAPATH_R5_EN.
module datapath_regs #(
    parameter int                DATA_W   = 16,
    parameter int                OPC_W    = 6,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    output logic [OPC_W-1:0]  instruction,
    output logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] bus
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic [DATA_W-1:0] r3_q, r3_d;
    logic [DATA_W-1:0] r4_q, r4_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] r5_val;
    logic [DATA_W-1:0] bus_w;
    logic [DATA_W-1:0] alu_res;

`ifdef DATAPATH_R5_EN
    logic [DATA_W-1:0] r5_q, r5_d;

    // R5 next state: clear beats load
    always_comb begin
        r5_d = r5_q;
        if (clr_en[6]) begin
            r5_d = '0;
        end else if (write_en[6]) begin
            r5_d = bus_w;
        end
    end

    // R5 storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r5_q <= '0;
        end else begin
            r5_q <= r5_d;
        end
    end

    assign r5_val = r5_q;
`else
    assign r5_val = '0;
`endif

    // Shared bus source mux
    always_comb begin
        bus_w = '0;
        case (read_en)
            4'd1:    bus_w = pc_q;
            4'd2:    bus_w = ar_q;
            4'd3:    bus_w = dr_q;
            4'd4:    bus_w = ir_q;
            4'd5:    bus_w = ac_q;
            4'd6:    bus_w = r_q;
            4'd7:    bus_w = r1_q;
            4'd8:    bus_w = r2_q;
            4'd9:    bus_w = r3_q;
            4'd10:   bus_w = r4_q;
            4'd11:   bus_w = r5_val;
            4'd12:   bus_w = dm_rdata;
            4'd13:   bus_w = im_data;
            default: bus_w = '0;
        endcase
    end

    // ALU result from the latched operands; unknown ops pass opA
    always_comb begin
        alu_res = opa_q;
        case (alu_op)
            3'd1:    alu_res = opa_q + opb_q;
            3'd2:    alu_res = opa_q - opb_q;
            3'd3:    alu_res = opa_q * opb_q;
            3'd4:    alu_res = {opa_q[DATA_W-2:0], 1'b0};
            default: alu_res = opa_q;
        endcase
    end

    // PC next state: clear > load > increment
    always_comb begin
        pc_d = pc_q;
        if (clr_en[1]) begin
            pc_d = '0;
        end else if (write_en[1]) begin
            pc_d = bus_w;
        end else if (inc_en[1]) begin
            pc_d = pc_q + ONE;
        end
    end

    // AC next state: clear > ALU result > bus load > increment
    always_comb begin
        ac_d = ac_q;
        if (clr_en[4]) begin
            ac_d = '0;
        end else if (write_en[12]) begin
            ac_d = alu_res;
        end else if (write_en[4]) begin
            ac_d = bus_w;
        end else if (inc_en[4]) begin
            ac_d = ac_q + ONE;
        end
    end

    // Plain registers: clear beats bus load
    always_comb begin
        ar_d = ar_q;
        ir_d = ir_q;
        r_d  = r_q;
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        r4_d = r4_q;
        if (clr_en[2]) ar_d = '0;
        else if (write_en[2]) ar_d = bus_w;
        if (clr_en[3]) ir_d = '0;
        else if (write_en[3]) ir_d = bus_w;
        if (clr_en[5]) r_d = '0;
        else if (write_en[5]) r_d = bus_w;
        if (clr_en[10]) r1_d = '0;
        else if (write_en[10]) r1_d = bus_w;
        if (clr_en[9]) r2_d = '0;
        else if (write_en[9]) r2_d = bus_w;
        if (clr_en[8]) r3_d = '0;
        else if (write_en[8]) r3_d = bus_w;
        if (clr_en[7]) r4_d = '0;
        else if (write_en[7]) r4_d = bus_w;
    end

    // DR captures memory data whenever the bus reads DM
    always_comb begin
        dr_d = dr_q;
        if (read_en == 4'd12) begin
            dr_d = dm_rdata;
        end
    end

    // ALU operand latches hold until the next latch strobe
    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (write_en[14]) begin
            opa_d = ac_q;
            opb_d = r_q;
        end
    end

    // Register bank storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= PC_RESET;
            ar_q  <= '0;
            dr_q  <= '0;
            ir_q  <= '0;
            ac_q  <= '0;
            r_q   <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ar_q  <= ar_d;
            dr_q  <= dr_d;
            ir_q  <= ir_d;
            ac_q  <= ac_d;
            r_q   <= r_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            r4_q  <= r4_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    assign bus         = bus_w;
    assign instruction = ir_q[OPC_W-1:0];
    assign z           = {{(DATA_W-1){1'b0}}, (ac_q == '0)};
    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = ac_q;
    assign dm_we       = write_en[11] & ~rst;

    // Strobe bits with no function in this datapath
    logic unused_strobes;
    assign unused_strobes = ^{write_en[15], write_en[13], write_en[6],
                              write_en[0], inc_en[15:5], inc_en[3:2],
                              inc_en[0], clr_en[15:11], clr_en[6],
                              clr_en[0]};

endmodule

// File: tb/tb_datapath_regs.sv
// Randomized self-checking bench for datapath_regs.
// Reference model is a register array indexed by bus source code.
module tb_datapath_regs;

    localparam int W = 16;
`ifdef DATAPATH_R5_EN
    localparam bit HAS_R5 = 1'b1;
`else
    localparam bit HAS_R5 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    read_en;
    logic [15:0]   write_en;
    logic [15:0]   inc_en;
    logic [15:0]   clr_en;
    logic [2:0]    alu_op;
    logic [5:0]    instruction;
    logic [W-1:0]  z;
    logic [W-1:0]  im_addr;
    logic [W-1:0]  im_data;
    logic [W-1:0]  dm_addr;
    logic [W-1:0]  dm_wdata;
    logic          dm_we;
    logic [W-1:0]  dm_rdata;
    logic [W-1:0]  bus;

    always #5 clk = ~clk;

    datapath_regs dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
        .instruction(instruction), .z(z), .im_addr(im_addr),
        .im_data(im_data), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_we(dm_we), .dm_rdata(dm_rdata), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index = bus source code (1 PC .. 11 R5)
    logic [W-1:0] m [0:11];
    logic [W-1:0] m_opa, m_opb;
    logic [W-1:0] last_bus;
    // strobe bit -> model register index (-1: none)
    int reg_of_bit [0:15] = '{-1, 1, 2, 4, 5, 6, 11, 10, 9, 8, 7,
                              -1, -1, -1, -1, -1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_bus(input logic [3:0] re);
        if (re == 0 || re >= 14) return '0;
        if (re == 12) return dm_rdata;
        if (re == 13) return im_data;
        if (re == 11) return HAS_R5 ? m[11] : '0;
        return m[re];
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [2:0] op);
        logic [31:0] a, b, r;
        a = {16'd0, m_opa};
        b = {16'd0, m_opb};
        case (op)
            3'd1:    r = a + b;
            3'd2:    r = a - b;
            3'd3:    r = a * b;
            3'd4:    r = a << 1;
            default: r = a;
        endcase
        return r[W-1:0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 12; i++) m[i] = '0;
        m_opa = '0;
        m_opb = '0;
    endtask

    task automatic m_step(input logic [W-1:0] b, input logic [W-1:0] alu);
        logic [W-1:0] nm [0:11];
        nm = m;
        for (int k = 1; k <= 10; k++) begin
            int idx;
            idx = reg_of_bit[k];
            if (k == 6 && !HAS_R5) continue;
            if (clr_en[k]) nm[idx] = '0;
            else if (k == 4 && write_en[12]) nm[idx] = alu;
            else if (write_en[k]) nm[idx] = b;
            else if (inc_en[k] && (k == 1 || k == 4))
                nm[idx] = m[idx] + 16'd1;
        end
        if (read_en == 4'd12) nm[3] = dm_rdata;
        if (write_en[14]) begin
            m_opa = m[5];
            m_opb = m[6];
        end
        m = nm;
    endtask

    task automatic check_outs();
        chk("bus", bus, m_bus(read_en));
        chk("z", z, {15'd0, m[5] == 16'd0});
        chk("instruction", instruction, m[4][5:0]);
        chk("im_addr", im_addr, m[1]);
        chk("dm_addr", dm_addr, m[2]);
        chk("dm_wdata", dm_wdata, m[5]);
        chk("dm_we", dm_we, write_en[11]);
    endtask

    // one clock: drive after negedge, check, step model at posedge
    task automatic cyc(input logic [3:0] re, input logic [15:0] we,
                       input logic [15:0] ie, input logic [15:0] ce,
                       input logic [2:0] op);
        logic [W-1:0] b, a;
        read_en  = re;
        write_en = we;
        inc_en   = ie;
        clr_en   = ce;
        alu_op   = op;
        #1;
        check_outs();
        last_bus = bus;
        b = m_bus(re);
        a = m_alu(op);
        @(posedge clk);
        m_step(b, a);
        @(negedge clk);
    endtask

    task automatic peek(input logic [3:0] re, input logic [W-1:0] exp,
                        input string tag);
        cyc(re, 16'd0, 16'd0, 16'd0, 3'd0);
        chk(tag, last_bus, exp);
    endtask

    task automatic load(input int bit_no, input logic [W-1:0] val);
        im_data = val;
        cyc(4'd13, 16'(1 << bit_no), 16'd0, 16'd0, 3'd0);
    endtask

    task automatic alu_do(input logic [2:0] op);
        cyc(4'd0, 16'h4000, 16'd0, 16'd0, 3'd0);
        cyc(4'd0, 16'h1000, 16'd0, 16'd0, op);
    endtask

    task automatic check_reset_state();
        chk("rst_bus", bus, 16'd0);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_z", z, 16'd1);
        chk("rst_pc", im_addr, 16'd0);
        chk("rst_ar", dm_addr, 16'd0);
        chk("rst_ac", dm_wdata, 16'd0);
        chk("rst_instr", instruction, 6'd0);
    endtask

    // async reset asserted mid-cycle with strobes pending
    task automatic mid_reset();
        read_en  = 4'd0;
        write_en = 16'($urandom) | 16'h0800;
        inc_en   = 16'($urandom);
        clr_en   = 16'd0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk);
        @(negedge clk);
        write_en = '0;
        inc_en   = '0;
        rst      = 1'b0;
        m_reset();
        for (int i = 1; i <= 11; i++)
            peek(4'(i), 16'd0, $sformatf("rst_reg%0d", i));
    endtask

    initial begin
        rst      = 1'b1;
        read_en  = '0;
        write_en = '0;
        inc_en   = '0;
        clr_en   = '0;
        alu_op   = '0;
        im_data  = '0;
        dm_rdata = '0;
        m_reset();
        @(negedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // fetch and PC increment
        im_data = 16'h0013;
        cyc(4'd13, 16'h0008, 16'd0, 16'd0, 3'd0);
        cyc(4'd0, 16'd0, 16'h0002, 16'd0, 3'd0);
        chk("fetch_instr", instruction, 6'h13);
        peek(4'd1, 16'h0001, "pc_inc");

        // subtract, then wrap below zero
        load(4, 16'h0007);
        load(5, 16'h0005);
        alu_do(3'd2);
        peek(4'd5, 16'h0002, "sub1");
        alu_do(3'd2);
        peek(4'd5, 16'hFFFD, "sub_wrap");

        // multiply overflow and left shift
        load(4, 16'h0100);
        load(5, 16'h0100);
        alu_do(3'd3);
        chk("mult_z", z, 16'd1);
        peek(4'd5, 16'h0000, "mult");
        load(4, 16'h8001);
        alu_do(3'd4);
        peek(4'd5, 16'h0002, "lshift");
        load(4, 16'h1234);
        load(5, 16'h0F0F);
        alu_do(3'd1);
        peek(4'd5, 16'h2143, "add");
        alu_do(3'd6);
        peek(4'd5, 16'h2143, "pass");

        // AC priority: clear wins, then ALU beats bus load
        load(4, 16'h0055);
        im_data = 16'h0077;
        cyc(4'd13, 16'h0010, 16'h0010, 16'h0010, 3'd0);
        peek(4'd5, 16'h0000, "clr_prio");
        load(4, 16'h0005);
        load(5, 16'h0003);
        cyc(4'd0, 16'h4000, 16'd0, 16'd0, 3'd0);
        im_data = 16'h0077;
        cyc(4'd13, 16'h1010, 16'd0, 16'd0, 3'd1);
        peek(4'd5, 16'h0008, "alu_prio");

        // increment wraps
        load(1, 16'hFFFF);
        cyc(4'd0, 16'd0, 16'h0002, 16'd0, 3'd0);
        peek(4'd1, 16'h0000, "pc_wrap");
        load(4, 16'hFFFF);
        cyc(4'd0, 16'd0, 16'h0010, 16'd0, 3'd0);
        chk("ac_wrap_z", z, 16'd1);

        // register moves and optional R5
        load(4, 16'hABCD);
        cyc(4'd5, 16'h0400, 16'd0, 16'd0, 3'd0);
        cyc(4'd11, 16'h0040, 16'd0, 16'd0, 3'd0);
        peek(4'd7, 16'hABCD, "r1_move");
        cyc(4'd5, 16'h0040, 16'd0, 16'd0, 3'd0);
        peek(4'd11, HAS_R5 ? 16'hABCD : 16'h0000, "r5_read");

        // DR capture and DM write strobe
        dm_rdata = 16'h1234;
        cyc(4'd12, 16'h0800, 16'd0, 16'd0, 3'd0);
        dm_rdata = 16'h0000;
        peek(4'd3, 16'h1234, "dr_capture");

        // random traffic against the model, reset in the middle
        for (int n = 0; n < 400; n++) begin
            logic [15:0] we, ie, ce;
            if (n == 200) mid_reset();
            im_data  = 16'($urandom);
            dm_rdata = 16'($urandom);
            we = 16'($urandom & $urandom & $urandom);
            ie = 16'($urandom & $urandom);
            ce = 16'($urandom & $urandom & $urandom & $urandom);
            cyc(4'($urandom_range(0, 15)), we, ie, ce,
                3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
